// File: rtl/auto_gain_ctrl_param.sv
// -----------------------------------------------------------------------------
// auto_gain_ctrl_param
//
// Automatic gain controller for the ADC front end. Tracks the peak of unsigned
// ADC samples over a window of WIN_LEN valid samples and steps the PGA gain code
// down (peak above HI_TH) or up (peak below LO_TH). After every gain change,
// SETTLE_LEN valid samples are discarded while the analog path settles.
// `stable` rises once the peak has stayed in band for STABLE_WIN windows in a row.
//
// Optional feature macro: AGC_FAST_ATTACK_EN
//   When defined, a valid sample >= CLIP_TH during MEASURE immediately drops the
//   gain by one step (if not already 0) and restarts with a settle period.
//   When undefined, clipping is only seen through the window peak.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   adc_valid  in   one-cycle sample strobe
//   adc_data   in   unsigned ADC sample, DATA_W bits
//   gain_ctrl  out  current gain code (0 = lowest gain), reset to maximum
//   gain_upd   out  one-cycle pulse coincident with a new gain_ctrl value
//   stable     out  peak in band for STABLE_WIN consecutive windows
//   at_limit   out  last decision wanted to step beyond 0 or the maximum code
//   peak_out   out  peak of the last completed window
// -----------------------------------------------------------------------------
module auto_gain_ctrl_param #(
    parameter int DATA_W     = 12,
    parameter int GAIN_W     = 2,
    parameter int WIN_LEN    = 1024,
    parameter int SETTLE_LEN = 16,
    parameter int HI_TH      = 3276,
    parameter int LO_TH      = 1228,
    parameter int CLIP_TH    = 4000,
    parameter int STABLE_WIN = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              adc_valid,
    input  logic [DATA_W-1:0] adc_data,
    output logic [GAIN_W-1:0] gain_ctrl,
    output logic              gain_upd,
    output logic              stable,
    output logic              at_limit,
    output logic [DATA_W-1:0] peak_out
);

    localparam int CNT_MAX = (WIN_LEN > SETTLE_LEN) ? WIN_LEN : SETTLE_LEN;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam int STB_W   = $clog2(STABLE_WIN + 1);

    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_LEN - 1);
    localparam logic [CNT_W-1:0]  WIN_LAST    = CNT_W'(WIN_LEN - 1);
    localparam logic [DATA_W-1:0] HI_V        = DATA_W'(HI_TH);
    localparam logic [DATA_W-1:0] LO_V        = DATA_W'(LO_TH);
    localparam logic [DATA_W-1:0] CLIP_V      = DATA_W'(CLIP_TH);
    localparam logic [GAIN_W-1:0] GAIN_MAX    = '1;
    localparam logic [STB_W-1:0]  STB_MAX     = STB_W'(STABLE_WIN);

`ifdef AGC_FAST_ATTACK_EN
    localparam bit FA_EN = 1'b1;
`else
    localparam bit FA_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_SETTLE  = 2'd0,
        S_MEASURE = 2'd1,
        S_DECIDE  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_peak;
    logic [DATA_W-1:0] r_peak_out;
    logic [GAIN_W-1:0] r_gain;
    logic              r_upd;
    logic              r_lim;
    logic [STB_W-1:0]  r_stab;

    logic w_clip;
    logic w_settle_end;
    logic w_win_end;
    logic w_clip_dec;
    logic w_clip_lim;
    logic w_dec_down;
    logic w_dec_up;
    logic w_dec_lim;
    logic w_dec_band;

    function automatic logic [DATA_W-1:0] peak_max(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [STB_W-1:0] stab_sat_inc(input logic [STB_W-1:0] c);
        return (c == STB_MAX) ? c : c + STB_W'(1);
    endfunction

    // Constant-folds to 0 when the fast-attack path is not built.
    assign w_clip = FA_EN && (adc_data >= CLIP_V);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_SETTLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_settle_end = 1'b0;
        w_win_end    = 1'b0;
        w_clip_dec   = 1'b0;
        w_clip_lim   = 1'b0;
        w_dec_down   = 1'b0;
        w_dec_up     = 1'b0;
        w_dec_lim    = 1'b0;
        w_dec_band   = 1'b0;
        case (r_state)
            S_SETTLE: begin
                if (adc_valid && (r_cnt == SETTLE_LAST)) begin
                    w_settle_end = 1'b1;
                    w_state_nxt  = S_MEASURE;
                end
            end
            S_MEASURE: begin
                if (adc_valid) begin
                    // A clip that can still step down wins over window end.
                    if (w_clip && (r_gain != '0)) begin
                        w_clip_dec  = 1'b1;
                        w_state_nxt = S_SETTLE;
                    end else begin
                        w_clip_lim = w_clip;
                        if (r_cnt == WIN_LAST) begin
                            w_win_end   = 1'b1;
                            w_state_nxt = S_DECIDE;
                        end
                    end
                end
            end
            S_DECIDE: begin
                if (r_peak > HI_V) begin
                    if (r_gain != '0) w_dec_down = 1'b1;
                    else              w_dec_lim  = 1'b1;
                end else if (r_peak < LO_V) begin
                    if (r_gain != GAIN_MAX) w_dec_up  = 1'b1;
                    else                    w_dec_lim = 1'b1;
                end else begin
                    w_dec_band = 1'b1;
                end
                w_state_nxt = (w_dec_down || w_dec_up) ? S_SETTLE : S_MEASURE;
            end
            default: w_state_nxt = S_SETTLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_peak     <= '0;
            r_peak_out <= '0;
            r_gain     <= GAIN_MAX;
            r_upd      <= 1'b0;
            r_lim      <= 1'b0;
            r_stab     <= '0;
        end else begin
            r_upd <= 1'b0;
            case (r_state)
                S_SETTLE: begin
                    if (adc_valid) begin
                        if (w_settle_end) begin
                            r_cnt  <= '0;
                            r_peak <= '0;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                S_MEASURE: begin
                    if (w_clip_dec) begin
                        r_gain <= r_gain - GAIN_W'(1);
                        r_upd  <= 1'b1;
                        r_stab <= '0;
                        r_cnt  <= '0;
                        r_peak <= '0;
                    end else if (adc_valid) begin
                        r_peak <= peak_max(r_peak, adc_data);
                        r_cnt  <= w_win_end ? '0 : r_cnt + CNT_W'(1);
                        if (w_clip_lim) r_lim <= 1'b1;
                    end
                end
                S_DECIDE: begin
                    // Clearing here also covers the direct return to MEASURE.
                    r_peak_out <= r_peak;
                    r_peak     <= '0;
                    r_cnt      <= '0;
                    if (w_dec_down || w_dec_up) begin
                        r_gain <= w_dec_down ? r_gain - GAIN_W'(1) : r_gain + GAIN_W'(1);
                        r_upd  <= 1'b1;
                        r_lim  <= 1'b0;
                        r_stab <= '0;
                    end else if (w_dec_lim) begin
                        r_lim  <= 1'b1;
                        r_stab <= '0;
                    end else if (w_dec_band) begin
                        r_lim  <= 1'b0;
                        r_stab <= stab_sat_inc(r_stab);
                    end
                end
                default: ;
            endcase
        end
    end

    assign gain_ctrl = r_gain;
    assign gain_upd  = r_upd;
    assign stable    = (r_stab == STB_MAX);
    assign at_limit  = r_lim;
    assign peak_out  = r_peak_out;

endmodule
